// File: rtl/scr1_dmem_tcm_router_pkg.sv
// Shared memory-interface encodings for the data-side router: widths, commands,
// responses, the two downstream ports and the router's FSM states.
package scr1_dmem_tcm_router_pkg;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10,
    SCR1_MEM_WIDTH_ERROR = 2'b11
  } type_scr1_mem_width_e;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

  typedef enum logic {
    PORT_TCM = 1'b0,
    PORT_EXT = 1'b1
  } type_scr1_dmem_port_e;

  typedef enum logic {
    FSM_IDLE      = 1'b0,
    FSM_WAIT_RESP = 1'b1
  } type_router_fsm_e;

endpackage

// File: rtl/scr1_dmem_tcm_router.sv
// Routes core dmem requests to the TCM (port 0) or the external dmem port (port 1)
// by address, tracking the single outstanding transaction and returning its response.
module scr1_dmem_tcm_router
  import scr1_dmem_tcm_router_pkg::*;
#(
  parameter logic [31:0] TCM_ADDR_MASK    = 32'hFFFF0000,
  parameter logic [31:0] TCM_ADDR_PATTERN = 32'h00480000
) (
  input  logic        rst_n,
  input  logic        clk,
  // core side
  output logic        core_req_ack,
  input  logic        core_req,
  input  logic        core_cmd,
  input  logic [1:0]  core_width,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic [31:0] core_rdata,
  output logic [1:0]  core_resp,
  // port 0: TCM
  input  logic        tcm_req_ack,
  output logic        tcm_req,
  output logic        tcm_cmd,
  output logic [1:0]  tcm_width,
  output logic [31:0] tcm_addr,
  output logic [31:0] tcm_wdata,
  input  logic [31:0] tcm_rdata,
  input  logic [1:0]  tcm_resp,
  // port 1: external
  input  logic        ext_req_ack,
  output logic        ext_req,
  output logic        ext_cmd,
  output logic [1:0]  ext_width,
  output logic [31:0] ext_addr,
  output logic [31:0] ext_wdata,
  input  logic [31:0] ext_rdata,
  input  logic [1:0]  ext_resp
);

  type_router_fsm_e     fsm, fsm_next;
  type_scr1_dmem_port_e port_fsm, port_next, sel_new;
  logic [1:0]           resp_sel;
  logic                 resp_fin;
  logic                 can_accept;
  logic                 sel_ack;

  assign tcm_cmd   = core_cmd;
  assign tcm_width = core_width;
  assign tcm_addr  = core_addr;
  assign tcm_wdata = core_wdata;
  assign ext_cmd   = core_cmd;
  assign ext_width = core_width;
  assign ext_addr  = core_addr;
  assign ext_wdata = core_wdata;

  // A new request may be taken while idle or in the very cycle the current response ends.
  always_comb begin
    sel_new    = ((core_addr & TCM_ADDR_MASK) == TCM_ADDR_PATTERN) ? PORT_TCM : PORT_EXT;
    resp_sel   = (port_fsm == PORT_TCM) ? tcm_resp : ext_resp;
    resp_fin   = (fsm == FSM_WAIT_RESP) && (resp_sel != SCR1_MEM_RESP_NOTRDY);
    can_accept = (fsm == FSM_IDLE) || resp_fin;
    sel_ack    = (sel_new == PORT_TCM) ? tcm_req_ack : ext_req_ack;

    tcm_req      = core_req & can_accept & (sel_new == PORT_TCM);
    ext_req      = core_req & can_accept & (sel_new == PORT_EXT);
    core_req_ack = core_req & can_accept & sel_ack;

    fsm_next  = fsm;
    port_next = port_fsm;
    if (core_req_ack) begin
      fsm_next  = FSM_WAIT_RESP;
      port_next = sel_new;
    end else if (resp_fin) begin
      fsm_next  = FSM_IDLE;
    end

    core_resp  = SCR1_MEM_RESP_NOTRDY;
    core_rdata = 32'h0;
    if (fsm == FSM_WAIT_RESP) begin
      core_resp  = resp_sel;
      core_rdata = (port_fsm == PORT_TCM) ? tcm_rdata : ext_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm      <= FSM_IDLE;
      port_fsm <= PORT_TCM;
    end else begin
      fsm      <= fsm_next;
      port_fsm <= port_next;
    end
  end

endmodule

// File: tb/tb_scr1_dmem_tcm_router.sv
// Per-cycle vector table with a scoreboard queue of expected outputs, plus a
// hand-written asynchronous reset sequence in the middle of a transaction.
module tb_scr1_dmem_tcm_router;
  import scr1_dmem_tcm_router_pkg::*;

  typedef struct {
    logic        req;
    logic        cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        tack;
    logic        eack;
    logic [1:0]  tresp;
    logic [31:0] trd;
    logic [1:0]  eresp;
    logic [31:0] erd;
    logic        xAck;
    logic        xTreq;
    logic        xEreq;
    logic [1:0]  xResp;
    logic [31:0] xRdata;
  } vec_t;

  logic        rst_n, clk;
  logic        core_req_ack, core_req, core_cmd;
  logic [1:0]  core_width, core_resp;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic        tcm_req_ack, tcm_req, tcm_cmd;
  logic [1:0]  tcm_width, tcm_resp;
  logic [31:0] tcm_addr, tcm_wdata, tcm_rdata;
  logic        ext_req_ack, ext_req, ext_cmd;
  logic [1:0]  ext_width, ext_resp;
  logic [31:0] ext_addr, ext_wdata, ext_rdata;

  int   checkCount = 0;
  int   passCount  = 0;
  vec_t vecs[$];
  vec_t expQ[$];

  localparam logic [1:0] NR = SCR1_MEM_RESP_NOTRDY;
  localparam logic [1:0] OK = SCR1_MEM_RESP_RDY_OK;
  localparam logic [1:0] ER = SCR1_MEM_RESP_RDY_ER;
  localparam logic       RD = SCR1_MEM_CMD_RD;
  localparam logic       WR = SCR1_MEM_CMD_WR;

  scr1_dmem_tcm_router dut (
    .rst_n(rst_n), .clk(clk),
    .core_req_ack(core_req_ack), .core_req(core_req), .core_cmd(core_cmd),
    .core_width(core_width), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .core_resp(core_resp),
    .tcm_req_ack(tcm_req_ack), .tcm_req(tcm_req), .tcm_cmd(tcm_cmd),
    .tcm_width(tcm_width), .tcm_addr(tcm_addr), .tcm_wdata(tcm_wdata),
    .tcm_rdata(tcm_rdata), .tcm_resp(tcm_resp),
    .ext_req_ack(ext_req_ack), .ext_req(ext_req), .ext_cmd(ext_cmd),
    .ext_width(ext_width), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_rdata(ext_rdata), .ext_resp(ext_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic req, input logic cmd, input logic [31:0] addr,
    input logic tack, input logic eack,
    input logic [1:0] tresp, input logic [31:0] trd,
    input logic [1:0] eresp, input logic [31:0] erd,
    input logic xAck, input logic xTreq, input logic xEreq,
    input logic [1:0] xResp, input logic [31:0] xRdata);
    vec_t v;
    v.req = req; v.cmd = cmd; v.addr = addr; v.wdata = addr ^ 32'h5A5A_0F0F;
    v.tack = tack; v.eack = eack;
    v.tresp = tresp; v.trd = trd; v.eresp = eresp; v.erd = erd;
    v.xAck = xAck; v.xTreq = xTreq; v.xEreq = xEreq; v.xResp = xResp; v.xRdata = xRdata;
    return v;
  endfunction

  task automatic checkValue(input string name, input int idx,
                            input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s (vec %0d): got %h, expected %h", name, idx, act, exp);
  endtask

  task automatic applyStimulus(input vec_t v);
    core_req    = v.req;
    core_cmd    = v.cmd;
    core_width  = SCR1_MEM_WIDTH_WORD;
    core_addr   = v.addr;
    core_wdata  = v.wdata;
    tcm_req_ack = v.tack;
    ext_req_ack = v.eack;
    tcm_resp    = v.tresp;
    tcm_rdata   = v.trd;
    ext_resp    = v.eresp;
    ext_rdata   = v.erd;
    expQ.push_back(v);
  endtask

  task automatic checkOutput(input int idx);
    vec_t e;
    if (expQ.size() == 0) begin
      checkValue("scoreboard_empty", idx, 32'd0, 32'd1);
      return;
    end
    e = expQ.pop_front();
    checkValue("core_req_ack", idx, {31'd0, core_req_ack}, {31'd0, e.xAck});
    checkValue("tcm_req",      idx, {31'd0, tcm_req},      {31'd0, e.xTreq});
    checkValue("ext_req",      idx, {31'd0, ext_req},      {31'd0, e.xEreq});
    checkValue("core_resp",    idx, {30'd0, core_resp},    {30'd0, e.xResp});
    checkValue("core_rdata",   idx, core_rdata,            e.xRdata);
    checkValue("broadcast_addr", idx, tcm_addr ^ ext_addr ^ core_addr, e.addr);
    checkValue("broadcast_ctl", idx,
               {20'd0, tcm_cmd, ext_cmd, tcm_width, ext_width, 6'd0},
               {20'd0, e.cmd, e.cmd, SCR1_MEM_WIDTH_WORD, SCR1_MEM_WIDTH_WORD, 6'd0});
    checkValue("broadcast_wdata", idx, tcm_wdata & ext_wdata, e.wdata);
  endtask

  initial begin
    // idle: port acks high but no core request
    vecs.push_back(mk(0, RD, 32'h0048_0000, 1, 1, NR, 32'h1111_1111, NR, 32'h2222_2222, 0, 0, 0, NR, 32'h0));
    // TCM read
    vecs.push_back(mk(1, RD, 32'h0048_0010, 1, 0, NR, 32'h0, NR, 32'h0, 1, 1, 0, NR, 32'h0));
    vecs.push_back(mk(0, RD, 32'h0000_0000, 0, 0, OK, 32'hDEAD_BEEF, OK, 32'h0BAD_0BAD, 0, 0, 0, OK, 32'hDEAD_BEEF));
    // external write stalled by ext_req_ack for three cycles
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1, WR, 32'h0001_0000, 1, 0, NR, 32'h0, NR, 32'h0, 0, 0, 1, NR, 32'h0));
    vecs.push_back(mk(1, WR, 32'h0001_0000, 1, 1, NR, 32'h0, NR, 32'h0, 1, 0, 1, NR, 32'h0));
    vecs.push_back(mk(0, RD, 32'h0, 0, 0, NR, 32'h0, NR, 32'h0000_0055, 0, 0, 0, NR, 32'h0000_0055));
    vecs.push_back(mk(0, RD, 32'h0, 0, 0, OK, 32'h0, NR, 32'h0000_0066, 0, 0, 0, NR, 32'h0000_0066));
    vecs.push_back(mk(0, RD, 32'h0, 0, 0, NR, 32'h0, OK, 32'hCAFE_0001, 0, 0, 0, OK, 32'hCAFE_0001));
    // back-to-back TCM then external
    vecs.push_back(mk(1, RD, 32'h0048_0020, 1, 0, NR, 32'h0, NR, 32'h0, 1, 1, 0, NR, 32'h0));
    vecs.push_back(mk(1, RD, 32'h1000_0000, 0, 1, OK, 32'h1234_5678, NR, 32'h0, 1, 0, 1, OK, 32'h1234_5678));
    vecs.push_back(mk(0, RD, 32'h0, 0, 0, OK, 32'h0000_FFFF, NR, 32'h0, 0, 0, 0, NR, 32'h0));
    vecs.push_back(mk(0, RD, 32'h0, 0, 0, NR, 32'h0, OK, 32'hA5A5_A5A5, 0, 0, 0, OK, 32'hA5A5_A5A5));
    // external error, then a normal TCM access
    vecs.push_back(mk(1, RD, 32'h2000_0000, 0, 1, NR, 32'h0, NR, 32'h0, 1, 0, 1, NR, 32'h0));
    vecs.push_back(mk(0, RD, 32'h0, 0, 0, NR, 32'h0, ER, 32'h0, 0, 0, 0, ER, 32'h0));
    vecs.push_back(mk(1, RD, 32'h0048_0030, 1, 0, NR, 32'h0, ER, 32'h0, 1, 1, 0, NR, 32'h0));
    vecs.push_back(mk(0, RD, 32'h0, 0, 0, OK, 32'h0000_0077, NR, 32'h0, 0, 0, 0, OK, 32'h0000_0077));
    // TCM request held while the external response is pending
    vecs.push_back(mk(1, WR, 32'h3000_0000, 0, 1, NR, 32'h0, NR, 32'h0, 1, 0, 1, NR, 32'h0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(1, RD, 32'h0048_0040, 1, 1, NR, 32'h0, NR, 32'h0, 0, 0, 0, NR, 32'h0));
    vecs.push_back(mk(1, RD, 32'h0048_0040, 1, 1, NR, 32'h0, OK, 32'h0000_0099, 1, 1, 0, OK, 32'h0000_0099));
    vecs.push_back(mk(0, RD, 32'h0, 0, 0, OK, 32'h0000_0088, NR, 32'h0, 0, 0, 0, OK, 32'h0000_0088));

    rst_n = 1'b0;
    applyStimulus(mk(0, RD, 32'h0, 0, 0, NR, 32'h0, NR, 32'h0, 0, 0, 0, NR, 32'h0));
    void'(expQ.pop_front());
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkValue("reset_resp", -1, {30'd0, core_resp}, {30'd0, NR});
    checkValue("reset_rdata", -1, core_rdata, 32'h0);

    foreach (vecs[i]) begin
      @(posedge clk);
      #1 applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput(i);
    end

    // asynchronous reset while waiting for a TCM response
    @(posedge clk);
    #1 applyStimulus(mk(1, RD, 32'h0048_0050, 1, 0, NR, 32'h0, NR, 32'h0, 1, 1, 0, NR, 32'h0));
    @(negedge clk);
    checkOutput(100);
    @(posedge clk);
    #1 applyStimulus(mk(0, RD, 32'h0, 0, 0, NR, 32'h0000_ABCD, NR, 32'h0, 0, 0, 0, NR, 32'h0000_ABCD));
    @(negedge clk);
    checkOutput(101);
    #1 rst_n = 1'b0;
    #1;
    checkValue("async_reset_resp", 102, {30'd0, core_resp}, {30'd0, NR});
    checkValue("async_reset_rdata", 102, core_rdata, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(mk(0, RD, 32'h0, 0, 0, OK, 32'h0000_BEEF, NR, 32'h0, 0, 0, 0, NR, 32'h0));
    @(negedge clk);
    checkOutput(103);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
